// File: rtl/sprite_store_mp.sv
// rtl/sprite_store_mp.sv - multi-sprite pixel store with byte-stream loader and parallel read ports
// Loader FSM writes PPB pixels per accepted byte; each read port is an independent 1-cycle registered lookup.
module sprite_store_mp #(
   parameter int SPRITE_NUM  = 8,
   parameter int SPRITE_SIZE = 4096,
   parameter int PIXEL_BITS  = 4,
   parameter int READ_PORTS  = 2,
   localparam int SEL_W  = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1,
   localparam int ADDR_W = $clog2(SPRITE_SIZE),
   localparam int PPB    = 8 / PIXEL_BITS
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             ld_start,
   input  logic [SEL_W-1:0]                 ld_select,
   input  logic                             ld_abort,
   input  logic                             ld_valid,
   input  logic [7:0]                       ld_data,
   output logic                             ld_ready,
   output logic                             ld_busy,
   output logic                             ld_done,
   output logic [SPRITE_NUM-1:0]            sprite_loaded,
   input  logic [READ_PORTS-1:0]            r_en,
   input  logic [READ_PORTS*SEL_W-1:0]      r_select,
   input  logic [READ_PORTS*ADDR_W-1:0]     r_addr,
   output logic [READ_PORTS*PIXEL_BITS-1:0] r_data,
   output logic [READ_PORTS-1:0]            r_valid
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOAD = 1'b1;

   logic [0:0]            r_state;
   logic [SEL_W-1:0]      r_sel;
   logic [ADDR_W-1:0]     r_ptr;
   logic                  r_done;
   logic [SPRITE_NUM-1:0] r_loaded;
   logic [PIXEL_BITS-1:0] r_mem [SPRITE_NUM][SPRITE_SIZE];

   logic w_sel_ok;
   logic w_accept;
   logic w_last;

   // Compare in a widened domain so the range check stays meaningful when SPRITE_NUM is a power of two.
   assign w_sel_ok = ({1'b0, ld_select} < (SEL_W+1)'(SPRITE_NUM));
   assign ld_ready = (r_state == S_LOAD) && !ld_abort && !reset;
   assign w_accept = ld_ready && ld_valid;
   assign w_last   = (r_ptr == ADDR_W'(SPRITE_SIZE - PPB));

   assign ld_busy       = (r_state == S_LOAD);
   assign ld_done       = r_done;
   assign sprite_loaded = r_loaded;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_ptr    <= '0;
         r_done   <= 1'b0;
         r_loaded <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ld_start && w_sel_ok) begin
                  r_state             <= S_LOAD;
                  r_sel               <= ld_select;
                  r_ptr               <= '0;
                  r_loaded[ld_select] <= 1'b0;
               end
            end
            S_LOAD: begin
               if (ld_abort) begin
                  r_state <= S_IDLE;
               end else if (w_accept) begin
                  if (w_last) begin
                     r_state         <= S_IDLE;
                     r_done          <= 1'b1;
                     r_loaded[r_sel] <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + ADDR_W'(PPB);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // First pixel of a byte sits in the MSBs and lands at the lowest address.
   always_ff @(posedge clock) begin
      if (w_accept) begin
         for (int k = 0; k < PPB; k++) begin
            r_mem[r_sel][r_ptr + ADDR_W'(k)] <= ld_data[7 - k*PIXEL_BITS -: PIXEL_BITS];
         end
      end
   end

   logic [PIXEL_BITS-1:0] r_rd_data  [READ_PORTS];
   logic                  r_rd_valid [READ_PORTS];

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      logic [SEL_W-1:0]  w_rsel;
      logic [ADDR_W-1:0] w_raddr;
      logic              w_rok;

      assign w_rsel  = r_select[p*SEL_W +: SEL_W];
      assign w_raddr = r_addr[p*ADDR_W +: ADDR_W];
      assign w_rok   = ({1'b0, w_rsel} < (SEL_W+1)'(SPRITE_NUM)) &&
                       ({1'b0, w_raddr} < (ADDR_W+1)'(SPRITE_SIZE));

      // Non-blocking memory update gives read-before-write on a same-cycle collision.
      always_ff @(posedge clock) begin
         if (reset) begin
            r_rd_valid[p] <= 1'b0;
            r_rd_data[p]  <= '0;
         end else begin
            r_rd_valid[p] <= r_en[p];
            if (r_en[p]) begin
               r_rd_data[p] <= w_rok ? r_mem[w_rsel][w_raddr] : '0;
            end
         end
      end

      assign r_data[p*PIXEL_BITS +: PIXEL_BITS] = r_rd_data[p];
      assign r_valid[p] = r_rd_valid[p];
   end

endmodule

// File: tb/tb_sprite_store_mp.sv
// tb/tb_sprite_store_mp.sv - directed scoreboard bench for sprite_store_mp
// Instance A: 4 sprites x 16 px x 4 bpp; instance B: 5 sprites x 16 px x 2 bpp (out-of-range select).
module tb_sprite_store_mp;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic rst;

   logic       a_ld_start, a_ld_abort, a_ld_valid;
   logic [1:0] a_ld_select;
   logic [7:0] a_ld_data;
   logic       a_ld_ready, a_ld_busy, a_ld_done;
   logic [3:0] a_loaded;
   logic [1:0] a_r_en, a_r_valid;
   logic [3:0] a_r_select;
   logic [7:0] a_r_addr, a_r_data;

   logic       b_ld_start, b_ld_abort, b_ld_valid;
   logic [2:0] b_ld_select;
   logic [7:0] b_ld_data;
   logic       b_ld_ready, b_ld_busy, b_ld_done;
   logic [4:0] b_loaded;
   logic [1:0] b_r_en, b_r_valid;
   logic [5:0] b_r_select;
   logic [7:0] b_r_addr;
   logic [3:0] b_r_data;

   sprite_store_mp #(.SPRITE_NUM(4), .SPRITE_SIZE(16), .PIXEL_BITS(4), .READ_PORTS(2)) dut_a (
      .clock(clock), .reset(rst), .ld_start(a_ld_start), .ld_select(a_ld_select),
      .ld_abort(a_ld_abort), .ld_valid(a_ld_valid), .ld_data(a_ld_data),
      .ld_ready(a_ld_ready), .ld_busy(a_ld_busy), .ld_done(a_ld_done),
      .sprite_loaded(a_loaded), .r_en(a_r_en), .r_select(a_r_select),
      .r_addr(a_r_addr), .r_data(a_r_data), .r_valid(a_r_valid));

   sprite_store_mp #(.SPRITE_NUM(5), .SPRITE_SIZE(16), .PIXEL_BITS(2), .READ_PORTS(2)) dut_b (
      .clock(clock), .reset(rst), .ld_start(b_ld_start), .ld_select(b_ld_select),
      .ld_abort(b_ld_abort), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
      .ld_ready(b_ld_ready), .ld_busy(b_ld_busy), .ld_done(b_ld_done),
      .sprite_loaded(b_loaded), .r_en(b_r_en), .r_select(b_r_select),
      .r_addr(b_r_addr), .r_data(b_r_data), .r_valid(b_r_valid));

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int a_done_cnt = 0;
   int b_done_cnt = 0;
   logic [7:0] qa0[$];
   logic [7:0] qa1[$];
   logic [7:0] qb0[$];
   logic [7:0] qb1[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic no_exp(input string tag);
      n_checks++;
      n_fail++;
      $error("FAIL %s unexpected r_valid observed=1 expected=0", tag);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   always @(posedge clock) begin
      if (a_ld_done) a_done_cnt++;
      if (b_ld_done) b_done_cnt++;
   end

   always @(negedge clock) begin
      if (a_r_valid[0]) begin
         if (qa0.size() == 0) no_exp("a_p0");
         else chk("a_p0_rdata", 32'(a_r_data[3:0]), 32'(qa0.pop_front()));
      end
      if (a_r_valid[1]) begin
         if (qa1.size() == 0) no_exp("a_p1");
         else chk("a_p1_rdata", 32'(a_r_data[7:4]), 32'(qa1.pop_front()));
      end
      if (b_r_valid[0]) begin
         if (qb0.size() == 0) no_exp("b_p0");
         else chk("b_p0_rdata", 32'(b_r_data[1:0]), 32'(qb0.pop_front()));
      end
      if (b_r_valid[1]) begin
         if (qb1.size() == 0) no_exp("b_p1");
         else chk("b_p1_rdata", 32'(b_r_data[3:2]), 32'(qb1.pop_front()));
      end
   end

   task automatic read_a(input int p, input logic [1:0] sel, input logic [3:0] addr, input logic [3:0] exp);
      if (p == 0) qa0.push_back(8'(exp)); else qa1.push_back(8'(exp));
      a_r_en[p] = 1'b1;
      a_r_select[p*2 +: 2] = sel;
      a_r_addr[p*4 +: 4] = addr;
      tick;
      a_r_en[p] = 1'b0;
   endtask

   task automatic read_b(input int p, input logic [2:0] sel, input logic [3:0] addr, input logic [1:0] exp);
      if (p == 0) qb0.push_back(8'(exp)); else qb1.push_back(8'(exp));
      b_r_en[p] = 1'b1;
      b_r_select[p*3 +: 3] = sel;
      b_r_addr[p*4 +: 4] = addr;
      tick;
      b_r_en[p] = 1'b0;
   endtask

   // Feeds bytes {2n,2n+1}; toggle idles ld_valid every other cycle; abort_after>=0 aborts after that many bytes.
   task automatic load_a(input logic [1:0] sel, input bit toggle, input int abort_after, input logic [3:0] exp_loaded);
      int  acc = 0;
      int  cyc = 0;
      int  d0;
      bit  v;
      bit  aborted = 0;
      d0 = a_done_cnt;
      a_ld_select = sel;
      a_ld_start  = 1'b1;
      tick;
      a_ld_start = 1'b0;
      v = !toggle;
      while (acc < 8 && cyc < 40) begin
         if (abort_after >= 0 && acc == abort_after) begin
            a_ld_abort = 1'b1;
            a_ld_valid = 1'b1;
            a_ld_data  = 8'hFF;
            @(negedge clock);
            chk("a_abort_ready", 32'(a_ld_ready), 32'h0);
            tick;
            a_ld_abort = 1'b0;
            aborted = 1;
            break;
         end
         a_ld_valid = v;
         a_ld_data  = {4'(2*acc), 4'(2*acc+1)};
         @(negedge clock);
         if (a_ld_valid && a_ld_ready) acc++;
         tick;
         cyc++;
         if (toggle) v = !v;
      end
      a_ld_valid = 1'b0;
      if (cyc >= 40) chk("a_load_timeout", 32'(cyc), 32'd39);
      @(negedge clock);
      chk("a_busy_after_load", 32'(a_ld_busy), 32'h0);
      chk("a_done_pulse", 32'(a_ld_done), aborted ? 32'h0 : 32'h1);
      chk("a_loaded", 32'(a_loaded), 32'(exp_loaded));
      tick;
      @(negedge clock);
      chk("a_done_low", 32'(a_ld_done), 32'h0);
      chk("a_done_count", 32'(a_done_cnt - d0), aborted ? 32'h0 : 32'h1);
   endtask

   initial begin
      rst = 1'b1;
      a_ld_start = 0; a_ld_abort = 0; a_ld_valid = 0; a_ld_select = 0; a_ld_data = 0;
      a_r_en = 0; a_r_select = 0; a_r_addr = 0;
      b_ld_start = 0; b_ld_abort = 0; b_ld_valid = 0; b_ld_select = 0; b_ld_data = 0;
      b_r_en = 0; b_r_select = 0; b_r_addr = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_ready", 32'(a_ld_ready), 32'h0);
      chk("rst_busy", 32'(a_ld_busy), 32'h0);
      chk("rst_done", 32'(a_ld_done), 32'h0);
      chk("rst_loaded", 32'(a_loaded), 32'h0);
      chk("rst_rvalid", 32'(a_r_valid), 32'h0);
      chk("rst_rdata", 32'(a_r_data), 32'h0);
      @(posedge clock);
      #1 rst = 1'b0;
      tick;

      // Full load of sprite 2, then sequential readback
      load_a(2'd2, 0, -1, 4'b0100);
      for (int i = 0; i < 16; i++) read_a(0, 2'd2, 4'(i), 4'(i));
      tick;
      tick;
      @(negedge clock);
      chk("a_hold_rvalid", 32'(a_r_valid[0]), 32'h0);
      chk("a_hold_rdata", 32'(a_r_data[3:0]), 32'hF);

      // Throttled load into sprite 1
      load_a(2'd1, 1, -1, 4'b0110);
      for (int i = 0; i < 16; i++) read_a(1, 2'd1, 4'(i), 4'(i));

      // Abort after 3 bytes, then reload
      load_a(2'd2, 0, 3, 4'b0010);
      load_a(2'd2, 0, -1, 4'b0110);

      // Read/write collision on sprite 2 pixel 5
      a_ld_select = 2'd2; a_ld_start = 1'b1;
      tick;
      a_ld_start = 1'b0;
      a_ld_valid = 1'b1; a_ld_data = 8'h01;
      tick;
      a_ld_data = 8'h23;
      tick;
      a_ld_data = 8'hAB;
      qa0.push_back(8'h5);
      a_r_en[0] = 1'b1; a_r_select[1:0] = 2'd2; a_r_addr[3:0] = 4'd5;
      tick;
      a_ld_valid = 1'b0;
      qa0.push_back(8'hB);
      tick;
      a_r_en[0] = 1'b0;
      a_ld_abort = 1'b1;
      tick;
      a_ld_abort = 1'b0;
      @(negedge clock);
      chk("a_busy_after_abort", 32'(a_ld_busy), 32'h0);
      chk("a_loaded_after_abort", 32'(a_loaded), 32'h2);

      // Dual-port same-cycle read
      qa0.push_back(8'h3);
      qa1.push_back(8'hA);
      a_r_en = 2'b11;
      a_r_select = {2'd2, 2'd1};
      a_r_addr = {4'd4, 4'd3};
      tick;
      a_r_en = 2'b00;
      @(negedge clock);
      chk("a_dual_rvalid", 32'(a_r_valid), 32'h3);

      // Instance B: out-of-range start ignored
      b_ld_select = 3'd6; b_ld_start = 1'b1;
      tick;
      b_ld_start = 1'b0;
      @(negedge clock);
      chk("b_oor_start_busy", 32'(b_ld_busy), 32'h0);
      chk("b_oor_start_ready", 32'(b_ld_ready), 32'h0);

      // 2 bpp load of sprite 1
      b_ld_select = 3'd1; b_ld_start = 1'b1;
      tick;
      b_ld_start = 1'b0;
      b_ld_valid = 1'b1;
      b_ld_data = 8'hE4; tick;
      b_ld_data = 8'h1B; tick;
      b_ld_data = 8'hE4; tick;
      b_ld_data = 8'h1B; tick;
      b_ld_valid = 1'b0;
      @(negedge clock);
      chk("b_done_pulse", 32'(b_ld_done), 32'h1);
      chk("b_loaded", 32'(b_loaded), 32'h2);
      tick;
      read_b(0, 3'd1, 4'd0, 2'd3);
      read_b(0, 3'd1, 4'd1, 2'd2);
      read_b(0, 3'd1, 4'd2, 2'd1);
      read_b(0, 3'd1, 4'd3, 2'd0);
      read_b(1, 3'd1, 4'd7, 2'd3);

      // Port 0 in range, port 1 selects nonexistent sprite 5
      qb0.push_back(8'h1);
      qb1.push_back(8'h0);
      b_r_en = 2'b11;
      b_r_select = {3'd5, 3'd1};
      b_r_addr = {4'd5, 4'd5};
      tick;
      b_r_en = 2'b00;
      @(negedge clock);
      chk("b_dual_rvalid", 32'(b_r_valid), 32'h3);

      // Reset in the middle of a load
      b_ld_select = 3'd3; b_ld_start = 1'b1;
      tick;
      b_ld_start = 1'b0;
      b_ld_valid = 1'b1; b_ld_data = 8'h55;
      tick;
      rst = 1'b1;
      tick;
      @(negedge clock);
      chk("b_rst_ready", 32'(b_ld_ready), 32'h0);
      chk("b_rst_busy", 32'(b_ld_busy), 32'h0);
      chk("b_rst_done", 32'(b_ld_done), 32'h0);
      chk("b_rst_loaded", 32'(b_loaded), 32'h0);
      chk("b_rst_rvalid", 32'(b_r_valid), 32'h0);
      chk("b_rst_rdata", 32'(b_r_data), 32'h0);
      chk("a_rst_loaded", 32'(a_loaded), 32'h0);
      rst = 1'b0;
      b_ld_valid = 1'b0;
      tick;
      @(negedge clock);
      chk("b_idle_after_rst", 32'(b_ld_busy), 32'h0);

      chk("qa0_drained", 32'(qa0.size()), 32'h0);
      chk("qa1_drained", 32'(qa1.size()), 32'h0);
      chk("qb0_drained", 32'(qb0.size()), 32'h0);
      chk("qb1_drained", 32'(qb1.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
